// File: rtl/slow_memory_param.sv
// Line-wide memory model with configurable read/write latency, serving one cache port.
// Latency: RD_LAT / WR_LAT cycles from request sample to a one-cycle mem_ready pulse.
// Backpressure: requester holds a level request until mem_ready; overlapping read+write is flagged, not served.
module slow_memory_param #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int DEPTH_W = 10,
    parameter int RD_LAT  = 8,
    parameter int WR_LAT  = 8,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              err_both,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  busy_cycles
);

    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int LCW     = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [LCW-1:0] RD_LOAD = LCW'(RD_LAT - 1);
    localparam logic [LCW-1:0] WR_LOAD = LCW'(WR_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t               state, next_state;
    logic [LCW-1:0]       cnt;
    logic                 op_wr;
    logic [DEPTH_W-1:0]   idx;
    logic [DATA_W-1:0]    wdata_q;
    logic                 busy;

    logic [DATA_W-1:0]    mem [0:(1<<DEPTH_W)-1];

    logic                 unused_addr;
    assign unused_addr = ^mem_addr;

    logic                 req_one;
    logic                 req_both;
    logic [LCW-1:0]       load;
    logic                 enter_done;
    logic                 sel_wr;
    logic [DEPTH_W-1:0]   sel_idx;
    logic [DATA_W-1:0]    sel_wdata;

    assign req_one    = mem_read ^ mem_write;
    assign req_both   = mem_read & mem_write;
    assign load       = mem_write ? WR_LOAD : RD_LOAD;
    assign enter_done = (next_state == DONE) && (state != DONE);

    // A latency-1 access reaches DONE straight from IDLE, so it must use the live inputs.
    assign sel_wr    = (state == IDLE) ? mem_write                 : op_wr;
    assign sel_idx   = (state == IDLE) ? mem_addr[DEPTH_W-1:0]     : idx;
    assign sel_wdata = (state == IDLE) ? mem_wdata                 : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_one) next_state = (load == '0) ? DONE : WAIT;
            WAIT:    if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata_q     <= '0;
            mem_rdata   <= '0;
            err_both    <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
            busy_cycles <= '0;
        end else begin
            if (state == IDLE && req_one) begin
                cnt     <= load;
                op_wr   <= mem_write;
                idx     <= mem_addr[DEPTH_W-1:0];
                wdata_q <= mem_wdata;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == IDLE && req_both)
                err_both <= 1'b1;
            if (enter_done && !sel_wr) begin
                mem_rdata <= mem[sel_idx];
                if (rd_count != {CNT_W{1'b1}}) rd_count <= rd_count + 1'b1;
            end
            if (enter_done && sel_wr && wr_count != {CNT_W{1'b1}})
                wr_count <= wr_count + 1'b1;
            if (busy && busy_cycles != {CNT_W{1'b1}})
                busy_cycles <= busy_cycles + 1'b1;
        end
    end

    // Storage is deliberately not reset so preloaded images survive rst_n.
    always_ff @(posedge clk) begin
        if (enter_done && sel_wr)
            mem[sel_idx] <= sel_wdata;
    end

endmodule

// File: tb/tb_slow_memory_param.sv
// Directed bench: latency, write/read ordering, error flag, mid-op changes, reset abort, saturation.
module tb_slow_memory_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;

    logic         a_read, a_write;
    logic [27:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic         a_ready, a_err;
    logic [31:0]  a_rd_count, a_wr_count, a_busy;

    logic         b_read, b_write;
    logic [27:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic         b_ready, b_err;
    logic [3:0]   b_rd_count, b_wr_count, b_busy;

    slow_memory_param #(.RD_LAT(8), .WR_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(a_read), .mem_write(a_write), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_rdata(a_rdata), .mem_ready(a_ready), .err_both(a_err),
        .rd_count(a_rd_count), .wr_count(a_wr_count), .busy_cycles(a_busy)
    );

    slow_memory_param #(.RD_LAT(1), .WR_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_read(b_read), .mem_write(b_write), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_rdata(b_rdata), .mem_ready(b_ready), .err_both(b_err),
        .rd_count(b_rd_count), .wr_count(b_wr_count), .busy_cycles(b_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ready cycle (lat = -1 on timeout).
    task automatic access(input logic wr, input logic [27:0] addr, input logic [127:0] wd,
                          output int lat);
        a_read  = !wr;
        a_write = wr;
        a_addr  = addr;
        a_wdata = wd;
        lat     = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (a_ready) begin
                lat = k;
                break;
            end
        end
        a_read  = 1'b0;
        a_write = 1'b0;
    endtask

    task automatic finish_access(input string tag);
        @(negedge clk);
        check(tag, a_ready, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int lat;
    int ones, bad, seen;
    logic prev;
    logic [127:0] pat_a5;

    initial begin
        pat_a5  = {16{8'hA5}};
        rst_n   = 1'b0;
        a_read  = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        b_read  = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", a_ready, 1'b0);
        check("rst_rdata", a_rdata, 128'h0);
        check("rst_err", a_err, 1'b0);
        check("rst_rd_count", a_rd_count, 0);
        check("rst_wr_count", a_wr_count, 0);
        check("rst_busy", a_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload line 5, then reset: storage must survive it.
        access(1'b1, 28'd5, pat_a5, lat);
        check("wr5_lat", lat, 3);
        check("wr5_count", a_wr_count, 1);
        finish_access("wr5_ready_low");
        pulse_reset();

        access(1'b0, 28'd5, '0, lat);
        check("rd5_lat", lat, 8);
        check("rd5_data", a_rdata, pat_a5);
        check("rd5_rd_count", a_rd_count, 1);
        check("rd5_busy", a_busy, 8);
        check("rd5_wr_count_after_rst", a_wr_count, 0);
        finish_access("rd5_ready_low");
        check("rd5_busy_done", a_busy, 9);

        access(1'b1, 28'd9, 128'h1234, lat);
        check("wr9_lat", lat, 3);
        check("wr9_rdata_kept", a_rdata, pat_a5);
        check("wr9_count", a_wr_count, 1);
        finish_access("wr9_ready_low");
        access(1'b0, 28'd9, '0, lat);
        check("rd9_lat", lat, 8);
        check("rd9_data", a_rdata, 128'h1234);
        check("rd9_rd_count", a_rd_count, 2);
        finish_access("rd9_ready_low");

        access(1'b1, 28'd2, 128'h22, lat);
        finish_access("wr2_ready_low");
        access(1'b1, 28'd3, 128'h33, lat);
        finish_access("wr3_ready_low");

        // Address change and dropped request during WAIT.
        a_read = 1'b1; a_addr = 28'd2;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_addr = 28'd3;
                a_read = 1'b0;
            end
            if (a_ready) begin
                lat = k;
                break;
            end
        end
        check("midop_lat", lat, 8);
        check("midop_data", a_rdata, 128'h22);
        finish_access("midop_ready_low");

        access(1'b1, 28'd4, 128'h44, lat);
        finish_access("wr4_ready_low");

        // Reset in the middle of an overwrite of line 4.
        a_write = 1'b1; a_addr = 28'd4; a_wdata = 128'hDEAD;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        a_write = 1'b0;
        #1;
        check("abort_ready", a_ready, 1'b0);
        check("abort_wr_count", a_wr_count, 0);
        check("abort_busy", a_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        a_read = 1'b1; a_write = 1'b1; a_addr = 28'd4; a_wdata = 128'hBAD;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (a_ready) seen++;
        end
        a_read = 1'b0; a_write = 1'b0;
        check("both_err", a_err, 1'b1);
        repeat (10) begin
            @(negedge clk);
            if (a_ready) seen++;
        end
        check("both_no_ready", seen, 0);
        check("both_err_sticky", a_err, 1'b1);
        check("both_rd_count", a_rd_count, 0);
        check("both_wr_count", a_wr_count, 0);
        check("both_busy", a_busy, 0);
        access(1'b0, 28'd4, '0, lat);
        check("rd4_lat", lat, 8);
        check("rd4_old_data", a_rdata, 128'h44);
        check("rd4_err_sticky", a_err, 1'b1);
        finish_access("rd4_ready_low");

        // Latency-1 instance: held read gives a ready every second cycle.
        b_read = 1'b1;
        ones = 0; bad = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_ready) ones++;
            if (i > 0 && b_ready == prev) bad++;
            prev = b_ready;
        end
        b_read = 1'b0;
        check("lat1_ready_pulses", ones, 20);
        check("lat1_alternating", bad, 0);
        check("lat1_rd_count_sat", b_rd_count, 4'd15);
        check("lat1_busy_sat", b_busy, 4'd15);
        check("lat1_wr_count", b_wr_count, 4'd0);
        check("lat1_err", b_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
